// File: rtl/debounce_pkg.sv
// Shared switch timing constants for a 12 MHz core clock, with widths, plus a width-fit helper.
// Pure constants and a function: no latency, no flow control.
package debounce_pkg;
    localparam int DEBOUNCE_20MS   = 240000;
    localparam int DEBOUNCE_20MS_W = 18;
    localparam int REPEAT_500MS    = 6000000;
    localparam int REPEAT_500MS_W  = 23;
    localparam int REPEAT_100MS    = 1200000;
    localparam int REPEAT_100MS_W  = 21;

    // True when an unsigned counter of 'width' bits can represent 'value'.
    function automatic bit fits_width(input int width, input longint value);
        if (width >= 63) begin
            return 1'b1;
        end
        return (longint'(1) << width) > value;
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// One switch: synchroniser, debounced level, press/release pulses and auto-repeat train.
// Latency SYNC_STAGES+DEBOUNCE_LIMIT cycles pin-to-level; free-running, no backpressure.
module debounce_channel #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_LIMIT = 240000,
    parameter int DEBOUNCE_SIZE  = 18,
    parameter int REPEAT_DELAY   = 6000000,
    parameter int REPEAT_PERIOD  = 1200000,
    parameter int REPEAT_SIZE    = 23
) (
    input  logic clk,
    input  logic resetn,
    input  logic switch_in,
    output logic switch_out,
    output logic rise,
    output logic fall,
    output logic auto_repeat
);
    localparam logic [DEBOUNCE_SIZE-1:0] CNT_LAST = DEBOUNCE_SIZE'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic [DEBOUNCE_SIZE-1:0] cnt;
    logic                     st;
    logic                     s;
    logic                     accept;

    assign s          = sync_q[SYNC_STAGES-1];
    assign accept     = (s != st) && (cnt == CNT_LAST);
    assign switch_out = st;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            cnt    <= '0;
            st     <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], switch_in};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (s == st) begin
                cnt <= '0;
            end else if (accept) begin
                st   <= s;
                cnt  <= '0;
                rise <= s;
                fall <= !s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    if (REPEAT_PERIOD != 0) begin : g_repeat
        localparam logic [REPEAT_SIZE-1:0] DELAY_LAST  = REPEAT_SIZE'(REPEAT_DELAY - 1);
        localparam logic [REPEAT_SIZE-1:0] PERIOD_LAST = REPEAT_SIZE'(REPEAT_PERIOD - 1);

        logic [REPEAT_SIZE-1:0] rc;
        logic                   first;
        logic                   pulse;

        // A release being accepted this edge pre-empts any repeat due on the same edge.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                rc    <= '0;
                first <= 1'b0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (accept && s) begin
                    rc    <= '0;
                    first <= 1'b1;
                end else if (!st || accept) begin
                    rc <= '0;
                end else if (rc == (first ? DELAY_LAST : PERIOD_LAST)) begin
                    pulse <= 1'b1;
                    rc    <= '0;
                    first <= 1'b0;
                end else begin
                    rc <= rc + 1'b1;
                end
            end
        end

        assign auto_repeat = pulse;
    end else begin : g_no_repeat
        assign auto_repeat = 1'b0;
    end
endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer with per-channel edge/repeat pulses and a combined event flag.
// Level/pulse latency SYNC_STAGES+DEBOUNCE_LIMIT, any_event one cycle later; no backpressure.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_20MS,
    parameter int DEBOUNCE_SIZE  = DEBOUNCE_20MS_W,
    parameter int REPEAT_DELAY   = REPEAT_500MS,
    parameter int REPEAT_PERIOD  = REPEAT_100MS,
    parameter int REPEAT_SIZE    = REPEAT_500MS_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] switch_in,
    output logic [CHANNELS-1:0] switch_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] auto_repeat,
    output logic                any_event
);
    localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;

    if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
        $error("DEBOUNCE_LIMIT must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (!fits_width(DEBOUNCE_SIZE, longint'(DEBOUNCE_LIMIT))) begin : g_bad_dsize
        $error("DEBOUNCE_SIZE too small for DEBOUNCE_LIMIT");
    end
    if (REPEAT_PERIOD != 0 && (REPEAT_DELAY < 1 || !fits_width(REPEAT_SIZE, longint'(REPEAT_MAX)))) begin : g_bad_rsize
        $error("REPEAT_SIZE too small, or REPEAT_DELAY zero with auto-repeat enabled");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .DEBOUNCE_SIZE (DEBOUNCE_SIZE),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_SIZE   (REPEAT_SIZE)
        ) u_ch (
            .clk        (clk),
            .resetn     (resetn),
            .switch_in  (switch_in[i]),
            .switch_out (switch_out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .auto_repeat(auto_repeat[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |{rise, fall, auto_repeat};
        end
    end
endmodule
